// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, bus layouts and ALU op bit indices.
package exe_stage_pkg;

   localparam int DS_TO_ES_W = 137;
   localparam int ES_TO_MS_W = 71;

   // One-hot ALU operation bit positions
   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_SLT  = 2;
   localparam int OP_SLTU = 3;
   localparam int OP_AND  = 4;
   localparam int OP_NOR  = 5;
   localparam int OP_OR   = 6;
   localparam int OP_XOR  = 7;
   localparam int OP_SLL  = 8;
   localparam int OP_SRL  = 9;
   localparam int OP_SRA  = 10;
   localparam int OP_LUI  = 11;

   // Decoded bundle from ID, MSB first
   typedef struct packed {
      logic [11:0] alu_op;
      logic        load_op;
      logic        src1_is_sa;
      logic        src1_is_pc;
      logic        src2_is_simm;
      logic        src2_is_uimm;
      logic        src2_is_8;
      logic        gr_we;
      logic        mem_we;
      logic [4:0]  dest;
      logic [15:0] imm;
      logic [31:0] rs_value;
      logic [31:0] rt_value;
      logic [31:0] pc;
   } ds_bus_t;

   // Result bundle to MEM, MSB first
   typedef struct packed {
      logic        load_op;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } ms_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 12-operation ALU driven by a one-hot op vector; an all-zero op yields 0.
module exe_stage_alu
   import exe_stage_pkg::*;
(
   input  logic [11:0] alu_op,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);

   logic signed [31:0] src1_s;
   logic signed [31:0] src2_s;
   logic signed [31:0] sra_s;
   logic        [4:0]  shamt;
   logic        [31:0] add_res;
   logic        [31:0] sub_res;
   logic        [31:0] slt_res;
   logic        [31:0] sltu_res;
   logic        [31:0] sll_res;
   logic        [31:0] srl_res;
   logic        [31:0] lui_res;

   assign src1_s   = alu_src1;
   assign src2_s   = alu_src2;
   assign shamt    = alu_src1[4:0];

   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign slt_res  = {31'b0, (src1_s < src2_s)};
   assign sltu_res = {31'b0, (alu_src1 < alu_src2)};
   assign sll_res  = alu_src2 << shamt;
   assign srl_res  = alu_src2 >> shamt;
   assign sra_s    = src2_s >>> shamt;
   assign lui_res  = {alu_src2[15:0], 16'b0};

   // One-hot select: each op's result is masked by its enable bit and the results OR together
   always_comb begin
      alu_result = ({32{alu_op[OP_ADD ]}} & add_res)
                 | ({32{alu_op[OP_SUB ]}} & sub_res)
                 | ({32{alu_op[OP_SLT ]}} & slt_res)
                 | ({32{alu_op[OP_SLTU]}} & sltu_res)
                 | ({32{alu_op[OP_AND ]}} & (alu_src1 & alu_src2))
                 | ({32{alu_op[OP_NOR ]}} & ~(alu_src1 | alu_src2))
                 | ({32{alu_op[OP_OR  ]}} & (alu_src1 | alu_src2))
                 | ({32{alu_op[OP_XOR ]}} & (alu_src1 ^ alu_src2))
                 | ({32{alu_op[OP_SLL ]}} & sll_res)
                 | ({32{alu_op[OP_SRL ]}} & srl_res)
                 | ({32{alu_op[OP_SRA ]}} & sra_s)
                 | ({32{alu_op[OP_LUI ]}} & lui_res);
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: registers the ID bundle under valid/allowin, selects ALU operands,
// issues data-SRAM requests and exports forwarding information back to ID.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int DS_TO_ES_BUS_WD = DS_TO_ES_W,
   parameter int ES_TO_MS_BUS_WD = ES_TO_MS_W
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_allowin,
   input  logic                       ms_allowin,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       es_fwd_we,
   output logic [4:0]                 es_fwd_dest,
   output logic [31:0]                es_fwd_result,
   output logic                       es_fwd_is_load,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_wen,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
);

   logic        vld_p0;
   ds_bus_t     bus_p0;
   logic        ready_go;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] alu_result;
   ms_bus_t     ms_bus;

   // Execute completes in a single cycle
   assign ready_go       = 1'b1;
   assign es_allowin     = !vld_p0 || (ready_go && ms_allowin);
   assign es_to_ms_valid = vld_p0 && ready_go;

   // ---- ID -> EXE boundary ----
   // Valid bit advances whenever the stage can accept; otherwise the current instruction holds
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld_p0 <= 1'b0;
      end else if (es_allowin) begin
         vld_p0 <= ds_to_es_valid;
      end
   end

   // Bundle register captures only real transfers, so a stalled instruction stays frozen
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus_p0 <= '0;
      end else if (ds_to_es_valid && es_allowin) begin
         bus_p0 <= ds_to_es_bus;
      end
   end

   // Operand select; earlier flags take priority when several are set
   always_comb begin
      src1 = bus_p0.rs_value;
      if (bus_p0.src1_is_sa) begin
         src1 = {27'b0, bus_p0.imm[10:6]};
      end else if (bus_p0.src1_is_pc) begin
         src1 = bus_p0.pc;
      end

      src2 = bus_p0.rt_value;
      if (bus_p0.src2_is_simm) begin
         src2 = {{16{bus_p0.imm[15]}}, bus_p0.imm};
      end else if (bus_p0.src2_is_uimm) begin
         src2 = {16'b0, bus_p0.imm};
      end else if (bus_p0.src2_is_8) begin
         src2 = 32'd8;
      end
   end

   exe_stage_alu u_alu (
      .alu_op     (bus_p0.alu_op),
      .alu_src1   (src1),
      .alu_src2   (src2),
      .alu_result (alu_result)
   );

   // ---- EXE -> MEM boundary ----
   assign ms_bus.load_op    = bus_p0.load_op;
   assign ms_bus.gr_we      = bus_p0.gr_we;
   assign ms_bus.dest       = bus_p0.dest;
   assign ms_bus.alu_result = alu_result;
   assign ms_bus.pc         = bus_p0.pc;
   assign es_to_ms_bus      = ms_bus;

   // Forwarding to ID: a valid write to r0 is never a real producer
   assign es_fwd_we      = vld_p0 && bus_p0.gr_we && (bus_p0.dest != 5'd0);
   assign es_fwd_dest    = bus_p0.dest;
   assign es_fwd_result  = alu_result;
   assign es_fwd_is_load = vld_p0 && bus_p0.load_op;

   // Memory request fires only in the cycle the instruction leaves, and never while reset is held
   assign data_sram_en    = resetn && vld_p0 && (bus_p0.load_op || bus_p0.mem_we) && ms_allowin;
   assign data_sram_wen   = (data_sram_en && bus_p0.mem_we) ? 4'hf : 4'h0;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = bus_p0.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_exe_stage;

   typedef struct {
      logic [11:0] op;
      logic        load_op, sa, pcf, simm, uimm, s8, gr_we, mem_we;
      logic [4:0]  dest;
      logic [15:0] imm;
      logic [31:0] rs, rt, pc;
   } instr_t;

   logic          clk;
   logic          resetn;
   logic          ds_to_es_valid;
   logic [136:0]  ds_to_es_bus;
   logic          es_allowin;
   logic          ms_allowin;
   logic          es_to_ms_valid;
   logic [70:0]   es_to_ms_bus;
   logic          es_fwd_we;
   logic [4:0]    es_fwd_dest;
   logic [31:0]   es_fwd_result;
   logic          es_fwd_is_load;
   logic          data_sram_en;
   logic [3:0]    data_sram_wen;
   logic [31:0]   data_sram_addr;
   logic [31:0]   data_sram_wdata;

   int tests = 0;
   int fails = 0;

   instr_t cur;
   instr_t q[$];
   bit     model_on = 0;

   exe_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_allowin      (es_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .es_fwd_we       (es_fwd_we),
      .es_fwd_dest     (es_fwd_dest),
      .es_fwd_result   (es_fwd_result),
      .es_fwd_is_load  (es_fwd_is_load),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [136:0] pack(instr_t i);
      return {i.op, i.load_op, i.sa, i.pcf, i.simm, i.uimm, i.s8, i.gr_we, i.mem_we,
              i.dest, i.imm, i.rs, i.rt, i.pc};
   endfunction

   function automatic logic [31:0] ref_alu(logic [11:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      logic [4:0]  sh;
      r  = 32'd0;
      sh = a[4:0];
      if (op[0])  r |= a + b;
      if (op[1])  r |= a - b;
      if (op[2])  r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (op[3])  r |= (a < b) ? 32'd1 : 32'd0;
      if (op[4])  r |= a & b;
      if (op[5])  r |= ~(a | b);
      if (op[6])  r |= a | b;
      if (op[7])  r |= a ^ b;
      if (op[8])  r |= b << sh;
      if (op[9])  r |= b >> sh;
      if (op[10]) r |= b[31] ? ~((~b) >> sh) : (b >> sh);
      if (op[11]) r |= b << 16;
      return r;
   endfunction

   function automatic logic [31:0] ref_result(instr_t i);
      logic [31:0] a, b;
      a = i.sa ? {27'd0, i.imm[10:6]} : (i.pcf ? i.pc : i.rs);
      b = i.simm ? {{16{i.imm[15]}}, i.imm} : (i.uimm ? {16'd0, i.imm} : (i.s8 ? 32'd8 : i.rt));
      return ref_alu(i.op, a, b);
   endfunction

   task automatic check(input string nm, input logic [70:0] act, input logic [70:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: at most one instruction resident; leaves when MEM accepts
   always @(posedge clk) begin
      if (!resetn) begin
         q.delete();
         model_on = 1;
      end else if (model_on) begin
         if (q.size() != 0 && ms_allowin) q.delete(0);
         if (q.size() == 0 && ds_to_es_valid) q.push_back(cur);
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (model_on) begin
         logic   occ;
         instr_t h;
         logic   en;
         occ = (q.size() != 0);
         h   = occ ? q[0] : cur;
         en  = resetn && occ && (h.load_op || h.mem_we) && ms_allowin;
         check("m_allowin",  71'(es_allowin),     71'(!occ || ms_allowin));
         check("m_valid",    71'(es_to_ms_valid), 71'(occ));
         check("m_fwd_we",   71'(es_fwd_we),      71'(occ && h.gr_we && h.dest != 5'd0));
         check("m_fwd_load", 71'(es_fwd_is_load), 71'(occ && h.load_op));
         check("m_sram_en",  71'(data_sram_en),   71'(en));
         check("m_sram_wen", 71'(data_sram_wen),  71'((en && h.mem_we) ? 4'hf : 4'h0));
         if (occ) begin
            check("m_bus",   es_to_ms_bus, {h.load_op, h.gr_we, h.dest, ref_result(h), h.pc});
            check("m_fdest", 71'(es_fwd_dest),     71'(h.dest));
            check("m_fres",  71'(es_fwd_result),   71'(ref_result(h)));
            check("m_addr",  71'(data_sram_addr),  71'(ref_result(h)));
            check("m_wdata", 71'(data_sram_wdata), 71'(h.rt));
         end
      end
   end

   task automatic drive(input instr_t i, input logic v, input logic ma);
      cur            = i;
      ds_to_es_bus   = pack(i);
      ds_to_es_valid = v;
      ms_allowin     = ma;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   function automatic instr_t blank();
      instr_t i;
      i = '{op: 12'd0, load_op: 1'b0, sa: 1'b0, pcf: 1'b0, simm: 1'b0, uimm: 1'b0, s8: 1'b0,
            gr_we: 1'b0, mem_we: 1'b0, dest: 5'd0, imm: 16'd0, rs: 32'd0, rt: 32'd0, pc: 32'd0};
      return i;
   endfunction

   initial begin
      instr_t i;
      instr_t nop;
      nop = blank();
      resetn = 1'b0;
      drive(nop, 1'b0, 1'b0);

      // Reset state
      step(); step();
      resetn = 1'b1;
      drive(nop, 1'b0, 1'b1);
      sample();
      check("rst_allowin", 71'(es_allowin),     71'(1));
      check("rst_valid",   71'(es_to_ms_valid), 71'(0));
      check("rst_en",      71'(data_sram_en),   71'(0));
      check("rst_wen",     71'(data_sram_wen),  71'(0));
      check("rst_fwd_we",  71'(es_fwd_we),      71'(0));
      check("rst_fwd_ld",  71'(es_fwd_is_load), 71'(0));

      // addiu
      i = blank(); i.op = 12'h001; i.simm = 1; i.gr_we = 1; i.dest = 5'd7;
      i.rs = 32'h10; i.imm = 16'hffff; i.pc = 32'hbfc0_0100;
      drive(i, 1'b1, 1'b1); step(); drive(nop, 1'b0, 1'b1); sample();
      check("addiu_valid", 71'(es_to_ms_valid),       71'(1));
      check("addiu_res",   71'(es_to_ms_bus[63:32]),  71'(32'h0000_000f));
      check("addiu_dest",  71'(es_to_ms_bus[68:64]),  71'(7));
      step();

      // store stalled for three cycles
      i = blank(); i.op = 12'h001; i.simm = 1; i.mem_we = 1; i.rs = 32'h1000;
      i.imm = 16'd4; i.rt = 32'hdead_beef; i.pc = 32'hbfc0_0104;
      drive(i, 1'b1, 1'b0); step(); drive(nop, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         sample();
         check("sw_stall_wen",     71'(data_sram_wen), 71'(0));
         check("sw_stall_allowin", 71'(es_allowin),    71'(0));
         step();
      end
      ms_allowin = 1'b1;
      sample();
      check("sw_wen",   71'(data_sram_wen),   71'(4'hf));
      check("sw_addr",  71'(data_sram_addr),  71'(32'h1004));
      check("sw_wdata", 71'(data_sram_wdata), 71'(32'hdead_beef));
      step(); sample();
      check("sw_once", 71'(data_sram_wen), 71'(0));

      // back-to-back
      for (int k = 0; k < 4; k++) begin
         i = blank(); i.op = 12'h040; i.rs = k; i.rt = 32'h100; i.pc = 32'h8000_0000 + 4 * k;
         drive(i, 1'b1, 1'b1); step(); sample();
         check("b2b_valid",   71'(es_to_ms_valid),    71'(1));
         check("b2b_allowin", 71'(es_allowin),        71'(1));
         check("b2b_pc",      71'(es_to_ms_bus[31:0]), 71'(32'h8000_0000 + 4 * k));
      end
      drive(nop, 1'b0, 1'b1); step();

      // sll by sa, jal link
      i = blank(); i.op = 12'h100; i.sa = 1; i.imm = 16'h0100; i.rt = 32'h1;
      drive(i, 1'b1, 1'b1); step(); sample();
      check("sll_res", 71'(es_fwd_result), 71'(32'h10));
      i = blank(); i.op = 12'h001; i.pcf = 1; i.s8 = 1; i.pc = 32'hbfc0_0000;
      drive(i, 1'b1, 1'b1); step(); sample();
      check("jal_res", 71'(es_fwd_result), 71'(32'hbfc0_0008));

      // load forwarding; r0 is never forwarded
      i = blank(); i.op = 12'h001; i.simm = 1; i.load_op = 1; i.gr_we = 1; i.dest = 5'd5;
      drive(i, 1'b1, 1'b1); step(); sample();
      check("lw_is_load", 71'(es_fwd_is_load), 71'(1));
      check("lw_dest",    71'(es_fwd_dest),    71'(5));
      check("lw_we",      71'(es_fwd_we),      71'(1));
      i = blank(); i.op = 12'h001; i.gr_we = 1; i.dest = 5'd0;
      drive(i, 1'b1, 1'b1); step(); sample();
      check("r0_we", 71'(es_fwd_we), 71'(0));
      drive(nop, 1'b0, 1'b1); step();

      // reset while a store is stalled
      i = blank(); i.op = 12'h001; i.mem_we = 1; i.rs = 32'h2000; i.rt = 32'h55;
      drive(i, 1'b1, 1'b0); step();
      drive(nop, 1'b0, 1'b0); resetn = 1'b0; sample();
      check("rstmid_en", 71'(data_sram_en), 71'(0));
      step();
      resetn = 1'b1; drive(nop, 1'b0, 1'b1); sample();
      check("rstmid_valid",   71'(es_to_ms_valid), 71'(0));
      check("rstmid_allowin", 71'(es_allowin),     71'(1));
      check("rstmid_wen",     71'(data_sram_wen),  71'(0));
      step();

      // randomized traffic
      for (int c = 0; c < 2000; c++) begin
         i = blank();
         i.op      = ($urandom_range(0, 12) == 12) ? 12'd0 : 12'(12'd1 << $urandom_range(0, 11));
         i.load_op = ($urandom_range(0, 3) == 0);
         i.sa      = ($urandom_range(0, 3) == 0);
         i.pcf     = ($urandom_range(0, 3) == 0);
         i.simm    = ($urandom_range(0, 3) == 0);
         i.uimm    = ($urandom_range(0, 3) == 0);
         i.s8      = ($urandom_range(0, 3) == 0);
         i.gr_we   = ($urandom_range(0, 1) == 0);
         i.mem_we  = ($urandom_range(0, 3) == 0);
         i.dest    = 5'($urandom);
         i.imm     = 16'($urandom);
         i.rs      = $urandom;
         i.rt      = $urandom;
         i.pc      = $urandom;
         resetn    = ($urandom_range(0, 49) != 0);
         drive(i, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
         step();
      end

      resetn = 1'b1;
      drive(nop, 1'b0, 1'b1);
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
